// File: rtl/axi_lite_regbank.sv
// rtl/axi_lite_regbank.sv - parametrised AXI4-Lite register bank with single-cycle user port
// Optional feature macro: AXI_REGBANK_SLVERR_EN (SLVERR on out-of-range AXI accesses; OKAY when undefined)
module axi_lite_regbank #(
  parameter int NUMBER_OF_REGISTERS = 16,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10,
  parameter logic [NUMBER_OF_REGISTERS-1:0] RO_MASK = '0
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic [1:0]                        register_operation,
  input  logic [7:0]                        register_number,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     register_write,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     register_read,
  output logic [NUMBER_OF_REGISTERS-1:0]    register_changed
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam int NUM_BYTES = C_S_AXI_DATA_WIDTH / 8;

  localparam logic W_IDLE = 1'b0;
  localparam logic W_RESP = 1'b1;
  localparam logic R_IDLE = 1'b0;
  localparam logic R_DATA = 1'b1;

  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [NUMBER_OF_REGISTERS];

  logic w_state;
  logic r_state;
  logic wr_accept;
  logic rd_accept;
  logic [IDX_W-1:0] aw_idx;
  logic [IDX_W-1:0] ar_idx;
  logic aw_in_range;
  logic ar_in_range;
  logic user_in_range;
  logic [1:0] aw_resp;
  logic [1:0] ar_resp;
  logic [NUMBER_OF_REGISTERS-1:0] aw_hit;
  logic [NUMBER_OF_REGISTERS-1:0] user_wr_hit;
  logic [C_S_AXI_DATA_WIDTH-1:0] axi_rd_val;
  logic [C_S_AXI_DATA_WIDTH-1:0] user_rd_val;

  // Protection bits and the byte offset inside a word carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign aw_in_range = int'(aw_idx) < NUMBER_OF_REGISTERS;
  assign ar_in_range = int'(ar_idx) < NUMBER_OF_REGISTERS;
  assign user_in_range = int'(register_number) < NUMBER_OF_REGISTERS;

  // Readies are gated by reset so nothing is offered while the bank is clearing.
  assign wr_accept = !S_AXI_ARESET && (w_state == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_accept = !S_AXI_ARESET && (r_state == R_IDLE) && S_AXI_ARVALID;
  assign S_AXI_AWREADY = wr_accept;
  assign S_AXI_WREADY = wr_accept;
  assign S_AXI_ARREADY = rd_accept;

`ifdef AXI_REGBANK_SLVERR_EN
  assign aw_resp = aw_in_range ? 2'b00 : 2'b10;
  assign ar_resp = ar_in_range ? 2'b00 : 2'b10;
`else
  assign aw_resp = 2'b00;
  assign ar_resp = 2'b00;
`endif

  // Per-register decode of the AXI write target and the user write target.
  always_comb begin
    aw_hit = '0;
    user_wr_hit = '0;
    for (int i = 0; i < NUMBER_OF_REGISTERS; i++) begin
      aw_hit[i] = aw_in_range && (aw_idx == IDX_W'(i)) && !RO_MASK[i];
      user_wr_hit[i] = (register_operation == OP_WRITE) && user_in_range && (register_number == 8'(i));
    end
  end

  // Read muxes; out-of-range indices yield zero.
  always_comb begin
    axi_rd_val = '0;
    user_rd_val = '0;
    for (int i = 0; i < NUMBER_OF_REGISTERS; i++) begin
      if (ar_in_range && (ar_idx == IDX_W'(i)))
        axi_rd_val = regs[i];
      if (user_in_range && (register_number == 8'(i)))
        user_rd_val = regs[i];
    end
  end

  // Register storage: AXI byte-lane writes first, a same-cycle user write overrides.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < NUMBER_OF_REGISTERS; i++)
        regs[i] <= '0;
      register_changed <= '0;
    end else begin
      for (int i = 0; i < NUMBER_OF_REGISTERS; i++) begin
        register_changed[i] <= wr_accept && aw_hit[i];
        if (wr_accept && aw_hit[i]) begin
          for (int b = 0; b < NUM_BYTES; b++)
            if (S_AXI_WSTRB[b])
              regs[i][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
        if (user_wr_hit[i])
          regs[i] <= register_write;
      end
    end
  end

  // Write response FSM: response is held until the master takes it.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state <= W_IDLE;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP <= 2'b00;
    end else begin
      case (w_state)
        W_IDLE: if (wr_accept) begin
          w_state <= W_RESP;
          S_AXI_BVALID <= 1'b1;
          S_AXI_BRESP <= aw_resp;
        end
        W_RESP: if (S_AXI_BREADY) begin
          w_state <= W_IDLE;
          S_AXI_BVALID <= 1'b0;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read data FSM: data is captured at accept and frozen until RREADY.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state <= R_IDLE;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: if (rd_accept) begin
          r_state <= R_DATA;
          S_AXI_RVALID <= 1'b1;
          S_AXI_RDATA <= axi_rd_val;
          S_AXI_RRESP <= ar_resp;
        end
        R_DATA: if (S_AXI_RREADY) begin
          r_state <= R_IDLE;
          S_AXI_RVALID <= 1'b0;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // User read port: samples the pre-write value and holds it until the next read op.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET)
      register_read <= '0;
    else if (register_operation == OP_READ)
      register_read <= user_rd_val;
  end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// tb/tb_axi_lite_regbank.sv - directed self-checking bench for axi_lite_regbank
module tb_axi_lite_regbank;

  localparam int N = 16;

`ifdef AXI_REGBANK_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic clk;
  logic areset;
  logic [9:0] awaddr;
  logic [2:0] awprot;
  logic awvalid;
  logic awready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wvalid;
  logic wready;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  logic [9:0] araddr;
  logic [2:0] arprot;
  logic arvalid;
  logic arready;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rvalid;
  logic rready;
  logic [1:0] reg_op;
  logic [7:0] reg_num;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic [N-1:0] changed;

  int checks = 0;
  int errors = 0;

  axi_lite_regbank #(
    .NUMBER_OF_REGISTERS(N),
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(10),
    .RO_MASK(16'h0002)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESET(areset),
    .S_AXI_AWADDR(awaddr),
    .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .register_operation(reg_op),
    .register_number(reg_num),
    .register_write(reg_wdata),
    .register_read(reg_rdata),
    .register_changed(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; clears any user op at the negedge after accept.
  task automatic axi_write(input string tag, input logic [9:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp, input logic [N-1:0] exp_chg);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    #1;
    check({tag, "/awready"}, 32'(awready), 32'd1);
    check({tag, "/wready"}, 32'(wready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; reg_op = 2'd0;
    check({tag, "/bvalid"}, 32'(bvalid), 32'd1);
    check({tag, "/bresp"}, 32'(bresp), 32'(exp_resp));
    check({tag, "/changed"}, 32'(changed), 32'(exp_chg));
    bready = 1'b1;
    @(negedge clk);
    check({tag, "/bvalid_clr"}, 32'(bvalid), 32'd0);
    check({tag, "/changed_clr"}, 32'(changed), 32'd0);
    bready = 1'b0;
  endtask

  task automatic axi_read(input string tag, input logic [9:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    #1;
    check({tag, "/arready"}, 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    check({tag, "/rvalid"}, 32'(rvalid), 32'd1);
    check({tag, "/rdata"}, rdata, exp_data);
    check({tag, "/rresp"}, 32'(rresp), 32'(exp_resp));
    rready = 1'b1;
    @(negedge clk);
    check({tag, "/rvalid_clr"}, 32'(rvalid), 32'd0);
    rready = 1'b0;
  endtask

  task automatic user_write(input logic [7:0] num, input logic [31:0] data);
    reg_op = 2'd2; reg_num = num; reg_wdata = data;
    @(negedge clk);
    reg_op = 2'd0;
  endtask

  task automatic user_read(input string tag, input logic [7:0] num, input logic [31:0] exp);
    reg_op = 2'd1; reg_num = num;
    @(negedge clk);
    reg_op = 2'd0;
    check(tag, reg_rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    awaddr = '0; awprot = '0; wdata = '0; wstrb = '0; bready = 1'b0;
    araddr = '0; arprot = '0; rready = 1'b0;
    reg_op = 2'd0; reg_num = '0; reg_wdata = '0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst/awready", 32'(awready), 32'd0);
    check("rst/arready", 32'(arready), 32'd0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    areset = 1'b0;
    @(negedge clk);
    check("rst/bvalid", 32'(bvalid), 32'd0);
    check("rst/rvalid", 32'(rvalid), 32'd0);
    check("rst/bresp", 32'(bresp), 32'd0);
    check("rst/rresp", 32'(rresp), 32'd0);
    check("rst/rdata", rdata, 32'd0);
    check("rst/register_read", reg_rdata, 32'd0);
    check("rst/changed", 32'(changed), 32'd0);

    // Basic full-word write/read on register 2.
    axi_write("w08", 10'h008, 32'hDEADBEEF, 4'hF, 2'b00, 16'h0004);
    axi_read("r08", 10'h008, 32'hDEADBEEF, 2'b00);

    // Byte strobes over an all-ones register 3.
    axi_write("w0c_ff", 10'h00C, 32'hFFFFFFFF, 4'hF, 2'b00, 16'h0008);
    axi_write("w0c_strb", 10'h00C, 32'h11223344, 4'h5, 2'b00, 16'h0008);
    axi_read("r0c_strb", 10'h00C, 32'hFF22FF44, 2'b00);

    // Read-only register 1: AXI dropped, user port allowed.
    axi_write("w04_ro", 10'h004, 32'h00000055, 4'hF, 2'b00, 16'h0000);
    axi_read("r04_ro", 10'h004, 32'h00000000, 2'b00);
    user_write(8'd1, 32'h000000A5);
    axi_read("r04_user", 10'h004, 32'h000000A5, 2'b00);

    // Out-of-range AXI accesses.
    axi_read("r3fc", 10'h3FC, 32'h00000000, OOR_RESP);
    axi_write("w3fc", 10'h3FC, 32'hCAFEBABE, 4'hF, OOR_RESP, 16'h0000);

    // Collision on register 3: user value wins, notification still fires.
    reg_op = 2'd2; reg_num = 8'd3; reg_wdata = 32'h00000002;
    axi_write("w0c_coll", 10'h00C, 32'h00000001, 4'hF, 2'b00, 16'h0008);
    axi_read("r0c_coll", 10'h00C, 32'h00000002, 2'b00);

    // Zero strobe still notifies but changes nothing.
    axi_write("w10_strb0", 10'h010, 32'hFFFFFFFF, 4'h0, 2'b00, 16'h0010);
    axi_read("r10_strb0", 10'h010, 32'h00000000, 2'b00);

    // User read sees the old value when AXI writes in the same cycle.
    reg_op = 2'd1; reg_num = 8'd2;
    axi_write("w08_rbw", 10'h008, 32'h0BADF00D, 4'hF, 2'b00, 16'h0004);
    check("user_rbw", reg_rdata, 32'hDEADBEEF);
    user_read("user_r2", 8'd2, 32'h0BADF00D);
    user_write(8'd200, 32'hFFFFFFFF);
    user_read("user_oor", 8'd200, 32'h00000000);

    // RDATA is frozen at accept even if the register changes while RREADY is low.
    araddr = 10'h008; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    user_write(8'd2, 32'hCAFEF00D);
    check("rdata_hold/rvalid", 32'(rvalid), 32'd1);
    check("rdata_hold/rdata", rdata, 32'h0BADF00D);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    axi_read("r08_new", 10'h008, 32'hCAFEF00D, 2'b00);

    // BREADY held low: response holds and no second accept.
    awaddr = 10'h018; wdata = 32'h600D0006; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("hold/bvalid", 32'(bvalid), 32'd1);
      check("hold/awready", 32'(awready), 32'd0);
      @(negedge clk);
    end
    wdata = 32'h12345678; bready = 1'b1;
    @(negedge clk);
    check("hold/release_bvalid", 32'(bvalid), 32'd0);
    check("hold/second_awready", 32'(awready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("hold/second_bvalid", 32'(bvalid), 32'd1);
    @(negedge clk);
    check("hold/second_bvalid_clr", 32'(bvalid), 32'd0);
    bready = 1'b0;
    axi_read("r18", 10'h018, 32'h12345678, 2'b00);

    // Reset in the middle of a pending read response.
    araddr = 10'h008; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    check("midrst/rvalid_before", 32'(rvalid), 32'd1);
    areset = 1'b1;
    @(negedge clk);
    check("midrst/rvalid_after", 32'(rvalid), 32'd0);
    areset = 1'b0;
    @(negedge clk);
    axi_read("midrst/r08", 10'h008, 32'h00000000, 2'b00);
    axi_read("midrst/r18", 10'h018, 32'h00000000, 2'b00);
    user_read("midrst/user_r1", 8'd1, 32'h00000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_regbank.md
# axi_lite_regbank

Parametrised AXI4-Lite slave register bank, the successor of the fixed-size slave used by the image-processing cores. It holds NUMBER_OF_REGISTERS 32-bit registers reachable from the PS over AXI4-Lite and from the processing fabric over a single-cycle user port. Over the previous generation it adds byte strobes, per-register read-only masking, out-of-range detection and per-register write-notification pulses. It sits between the AXI interconnect and the filter/statistics engines.

## Interface
- NUMBER_OF_REGISTERS, 16, register count, 1..256
- C_S_AXI_DATA_WIDTH, 32, data width, fixed at 32
- C_S_AXI_ADDR_WIDTH, 10, byte address width; must satisfy 2^(C_S_AXI_ADDR_WIDTH-2) >= NUMBER_OF_REGISTERS
- RO_MASK, 0, NUMBER_OF_REGISTERS-bit mask; bit i = 1 makes register i read-only from AXI

Ports:
- S_AXI_ACLK  in  1  single clock
- S_AXI_ARESET  in  1  reset, synchronous, active-high
- S_AXI_AW*/W*/B*/AR*/R*  AXI4-Lite slave channels, standard widths (AWPROT/ARPROT ignored)
- register_operation  in  2  user op: 0 idle, 1 read, 2 write, 3 no-op
- register_number  in  8  user register index
- register_write  in  32  user write data
- register_read  out  32  user read data
- register_changed  out  NUMBER_OF_REGISTERS  one-cycle pulse per register written from AXI

## Operation
- Register index = address[C_S_AXI_ADDR_WIDTH-1:2]; address bits [1:0] are ignored.
- AXI write:
  - Accepted when AWVALID & WVALID & !BVALID.
  - For each byte lane with WSTRB set, the register byte is updated unless the register's RO_MASK bit is 1.
  - RO writes are silently dropped with BRESP OKAY.
- AXI read returns the register value; RRESP OKAY.
- Out-of-range index (>= NUMBER_OF_REGISTERS): write dropped, read data 0; response per Configuration.
- User port:
  - op 2 writes all 32 bits, RO_MASK does not apply, so fabric can post status.
  - op 1 loads register_read.
  - Out-of-range user index: write ignored, read returns 0.
- Collision, same register written by AXI and user in the same cycle: user value is stored. BRESP stays OKAY and register_changed still pulses.
- register_changed[i] pulses one cycle after any accepted AXI write to in-range, non-RO register i, even if WSTRB = 0.
- Write FSM: W_IDLE -> W_RESP on accept -> W_IDLE when BREADY.
- Read FSM: R_IDLE -> R_DATA on accept -> R_IDLE when RREADY.

## Timing
- Reset values: all registers 0, AWREADY/WREADY/ARREADY/BVALID/RVALID 0, BRESP/RRESP 0, RDATA 0, register_read 0, register_changed 0.
- AWREADY and WREADY assert together for exactly one cycle, the accept cycle (combinational on the valids in W_IDLE).
- Register update at the end of the accept cycle. BVALID asserts the next cycle and holds with BRESP stable until BREADY.
- ARREADY asserts one cycle, in R_IDLE with ARVALID.
- RDATA/RVALID are registered: valid the cycle after accept, held stable until RREADY. RDATA is sampled at accept, so a later write does not alter it.
- Peak throughput is one write per 2 cycles and one read per 2 cycles; read and write channels are independent.
- User read latency 1: register_read reflects the value at the op-1 cycle edge, including a write in that same cycle (read-before-write, old value). It holds until the next op 1.
- Reset mid-transaction: the FSMs return to idle next edge, pending BVALID/RVALID drop, and registers clear.

## Configuration
- AXI_REGBANK_SLVERR_EN defined: out-of-range AXI accesses return BRESP/RRESP = 2'b10 (SLVERR).
- Undefined: out-of-range accesses return OKAY, read data 0.
- Both cases drop the write and assert no register_changed bit.

## Test plan
- Reset, then AXI write 0xDEADBEEF to addr 0x08, WSTRB 0xF -> BVALID 1 cycle later, BRESP 0; AXI read 0x08 -> RDATA 0xDEADBEEF; register_changed[2] pulses once.
- AXI write 0x11223344 to 0x0C with WSTRB 0x5 over 0xFFFFFFFF -> reads 0xFF22FF44.
- RO_MASK bit 1 set: AXI write 0x55 to 0x04 -> BRESP OKAY, value unchanged 0. User op 2 register_number 1 data 0xA5 -> AXI read 0x04 returns 0xA5.
- AXI read 0x3FC with NUMBER_OF_REGISTERS=16 -> RDATA 0. RRESP 2 with AXI_REGBANK_SLVERR_EN, 0 without.
- Same-cycle AXI write 0x1 and user write 0x2 to register 3 -> register 3 = 0x2, BRESP OKAY.
- BREADY held low 5 cycles -> BVALID stays 1, no new AWREADY. Assert S_AXI_ARESET mid-read -> RVALID 0 next cycle, all registers read 0 afterwards.
